// File: rtl/writeback_queue.sv
// writeback_queue: in-order result buffer feeding the register file write port,
// with youngest-wins forwarding of pending values to operand fetch.
module writeback_queue #(
  parameter int DEPTH      = 4,
  parameter int REG_ADDR_W = 6,
  parameter int DATA_W     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      out_ready,
  input  logic [REG_ADDR_W-1:0]     in_rd,
  input  logic [DATA_W-1:0]         in_rdval,
  input  logic                      in_stall,
  input  logic                      in_flush,
  output logic                      out_regwrt,
  output logic [REG_ADDR_W-1:0]     out_rd,
  output logic [DATA_W-1:0]         out_rdval,
  input  logic [REG_ADDR_W-1:0]     in_rs,
  input  logic [REG_ADDR_W-1:0]     in_rt,
  output logic                      out_rs_hit,
  output logic [DATA_W-1:0]         out_rsval,
  output logic                      out_rt_hit,
  output logic [DATA_W-1:0]         out_rtval,
  output logic [$clog2(DEPTH):0]    out_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [REG_ADDR_W-1:0] rd_q [DEPTH];
  logic [REG_ADDR_W-1:0] rd_d [DEPTH];
  logic [DATA_W-1:0]     val_q [DEPTH];
  logic [DATA_W-1:0]     val_d [DEPTH];
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d, idx;
  logic [CW-1:0]         count_q, count_d;
  logic                  push, pop, busy;
  assign busy       = count_q != '0;
  assign out_ready  = count_q < CW'(DEPTH);
  assign push       = in_valid && out_ready && !in_flush;
  assign pop        = busy && !in_stall && !in_flush;
  assign out_regwrt = pop;
  assign out_rd     = busy ? rd_q[head_q] : '0;
  assign out_rdval  = busy ? val_q[head_q] : '0;
  assign out_count  = count_q;
  always_comb begin
    rd_d    = rd_q;
    val_d   = val_q;
    if (push) begin
      rd_d[tail_q]  = in_rd;
      val_d[tail_q] = in_rdval;
    end
    head_d  = in_flush ? '0 : head_q + PW'(pop);
    tail_d  = in_flush ? '0 : tail_q + PW'(push);
    count_d = in_flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  // Walk oldest to youngest so a later match overwrites an earlier one.
  always_comb begin
    out_rs_hit = 1'b0;
    out_rsval  = '0;
    out_rt_hit = 1'b0;
    out_rtval  = '0;
    idx        = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q && rd_q[idx] == in_rs) begin
        out_rs_hit = 1'b1;
        out_rsval  = val_q[idx];
      end
      if (CW'(i) < count_q && rd_q[idx] == in_rt) begin
        out_rt_hit = 1'b1;
        out_rtval  = val_q[idx];
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= '0;
        val_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      val_q   <= val_d;
    end
  end
endmodule
